// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Handshake and data bundle between the execute stage and the divider.
//
// Signals:
//   signed_div_i  execute -> div  1   1 = signed divide, sampled with start_i
//   opdata1_i     execute -> div  32  dividend, sampled on acceptance
//   opdata2_i     execute -> div  32  divisor, sampled on acceptance
//   start_i       execute -> div  1   divide request, held until ready_o consumed
//   annul_i       execute -> div  1   flush the operation in flight
//   result_o      div -> execute  64  {remainder, quotient}, valid with ready_o
//   ready_o       div -> execute  1   result valid
//   stallreq_o    div -> execute  1   combinational pipeline stall request
//
// Modports: master = execute stage, slave = divider.
// -----------------------------------------------------------------------------
interface div_ctrl_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle 32-bit signed/unsigned divider for the execute stage. Runs a
// restoring shift/subtract over 32 iterations while requesting a pipeline
// stall, then presents {remainder, quotient} with a ready strobe until the
// execute stage drops its start request.
//
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   asynchronous active-low reset
//   bus   slave modport of div_ctrl_if (operands, start/annul, result/ready,
//         stall request)
// -----------------------------------------------------------------------------
module div_ctrl (
   input  logic      clk,
   input  logic      rst,
   div_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      BY_ZERO = 2'd1,
      ON      = 2'd2,
      END     = 2'd3
   } state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [64:0] r_work;      // {partial remainder (33), dividend/quotient (32)}
   logic [31:0] r_dvsr;      // |divisor|
   logic        r_neg_quot;  // negate quotient at the end
   logic        r_neg_rem;   // negate remainder at the end
   logic [63:0] r_result;
   logic        r_ready;

   // Operand conditioning at acceptance time
   logic        w_dend_neg;
   logic        w_dvsr_neg;
   logic [31:0] w_dend_abs;
   logic [31:0] w_dvsr_abs;

   assign w_dend_neg = bus.signed_div_i & bus.opdata1_i[31];
   assign w_dvsr_neg = bus.signed_div_i & bus.opdata2_i[31];
   assign w_dend_abs = w_dend_neg ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
   assign w_dvsr_abs = w_dvsr_neg ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

   // One restoring-division step. The partial remainder is always below the
   // divisor before the shift, so after the subtract bit 32 of the difference
   // alone tells whether the trial subtraction went negative.
   logic [32:0] w_diff;
   logic [64:0] w_work_next;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic [31:0] w_quot_fix;
   logic [31:0] w_rem_fix;

   assign w_diff      = r_work[64:32] - {1'b0, r_dvsr};
   assign w_work_next = w_diff[32] ? {r_work[63:0], 1'b0}
                                   : {w_diff[31:0], r_work[31:0], 1'b1};
   assign w_quot      = w_work_next[31:0];
   assign w_rem       = w_work_next[64:33];
   assign w_quot_fix  = r_neg_quot ? (~w_quot + 32'd1) : w_quot;
   assign w_rem_fix   = r_neg_rem  ? (~w_rem  + 32'd1) : w_rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= FREE;
         r_cnt      <= '0;
         r_work     <= '0;
         r_dvsr     <= '0;
         r_neg_quot <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_result   <= '0;
         r_ready    <= 1'b0;
      end else begin
         case (r_state)
            FREE: begin
               r_ready  <= 1'b0;
               r_result <= '0;
               if (bus.start_i && !bus.annul_i) begin
                  if (bus.opdata2_i == 32'd0) begin
                     r_state <= BY_ZERO;
                  end else begin
                     r_work     <= {32'd0, w_dend_abs, 1'b0};
                     r_dvsr     <= w_dvsr_abs;
                     r_neg_quot <= w_dend_neg ^ w_dvsr_neg;
                     r_neg_rem  <= w_dend_neg;
                     r_cnt      <= '0;
                     r_state    <= ON;
                  end
               end
            end

            BY_ZERO: begin
               r_result <= '0;
               r_ready  <= 1'b1;
               r_state  <= END;
            end

            ON: begin
               // A flush wins over the iteration on the same edge
               if (bus.annul_i) begin
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_state <= FREE;
               end else begin
                  r_work <= w_work_next;
                  r_cnt  <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) begin
                     r_result <= {w_rem_fix, w_quot_fix};
                     r_ready  <= 1'b1;
                     r_state  <= END;
                  end
               end
            end

            END: begin
               if (!bus.start_i) begin
                  r_ready  <= 1'b0;
                  r_result <= '0;
                  r_state  <= FREE;
               end else begin
                  r_ready <= 1'b1;
               end
            end

            default: r_state <= FREE;
         endcase
      end
   end

   assign bus.result_o   = r_result;
   assign bus.ready_o    = r_ready;
   assign bus.stallreq_o = (r_state == BY_ZERO) || (r_state == ON) ||
                           ((r_state == FREE) && bus.start_i);

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Directed-vector bench for div_ctrl with hand-computed expected results.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge (registered) or 1 time unit after driving (combinational stall).
// -----------------------------------------------------------------------------
module tb_div_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   div_ctrl_if bus ();

   div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec    = 0;
   int n_miscmp = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
   endtask

   // Called at a falling edge right after start_i is raised (cycle 0).
   // Counts falling edges until ready_o, and the cycles with stallreq_o high
   // before ready. Operands are scrambled once the start has been accepted.
   task automatic wait_ready(input logic scramble, output int cyc, output int stall_hi);
      cyc      = 0;
      stall_hi = 0;
      #1;
      if (bus.stallreq_o) stall_hi++;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (scramble && cyc == 1) begin
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = ~bus.signed_div_i;
         end
         if (bus.ready_o) break;
         #1;
         if (bus.stallreq_o) stall_hi++;
      end
      if (cyc != 0 && !bus.ready_o) cyc = 999;  // timed out
   endtask

   // Drop start after consuming the result and check the return to idle.
   task automatic release_op(input string tag);
      bus.start_i = 1'b0;
      #1;
      chk({tag, "/stall_idle"}, {63'd0, bus.stallreq_o}, 64'd0);
      @(negedge clk);
      chk({tag, "/ready_clr"}, {63'd0, bus.ready_o}, 64'd0);
      chk({tag, "/result_clr"}, bus.result_o, 64'd0);
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
      int cyc;
      int sh;
      drive_op(sgn, a, b);
      wait_ready(1'b1, cyc, sh);
      chk({tag, "/latency"}, 64'(cyc), 64'(lat));
      chk({tag, "/stall_cycles"}, 64'(sh), 64'(lat));
      chk({tag, "/result"}, bus.result_o, exp);
      #1;
      chk({tag, "/stall_at_ready"}, {63'd0, bus.stallreq_o}, 64'd0);
      @(negedge clk);
      chk({tag, "/ready_hold"}, {63'd0, bus.ready_o}, 64'd1);
      chk({tag, "/result_hold"}, bus.result_o, exp);
      $display("div %-12s sgn=%0d a=%h b=%h -> %h (lat %0d)", tag, sgn, a, b, bus.result_o, cyc);
      release_op(tag);
   endtask

   initial begin
      int cyc;
      int sh;

      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;

      // Reset state
      #2;
      chk("rst/ready", {63'd0, bus.ready_o}, 64'd0);
      chk("rst/result", bus.result_o, 64'd0);
      chk("rst/stall", {63'd0, bus.stallreq_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Main function and boundary cases
      run_div("u100/7",     1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
      run_div("s-100/7",    1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 33);
      run_div("s100/-7",    1'b1, 32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, 33);
      run_div("s-100/-7",   1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33);
      run_div("u-100/7",    1'b0, 32'hFFFFFF9C,   32'd7,          64'h00000002_24924916, 33);
      run_div("u/0",        1'b0, 32'd1234,       32'd0,          64'h0,                 2);
      run_div("s/0",        1'b1, 32'hFFFFFF9C,   32'd0,          64'h0,                 2);
      run_div("s_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
      run_div("uFFFF/1",    1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33);
      run_div("u8000/FFFF", 1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33);

      // Annul mid-divide, then immediate restart with start still held
      drive_op(1'b0, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i = 1'b0;
      chk("annul/ready", {63'd0, bus.ready_o}, 64'd0);
      chk("annul/result", bus.result_o, 64'd0);
      #1;
      chk("annul/stall_free", {63'd0, bus.stallreq_o}, 64'd1);
      wait_ready(1'b0, cyc, sh);
      chk("annul/restart_latency", 64'(cyc), 64'd33);
      chk("annul/restart_result", bus.result_o, 64'h00000002_0000000E);
      // annul is ignored once the result is presented
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i = 1'b0;
      chk("annul/end_ready", {63'd0, bus.ready_o}, 64'd1);
      chk("annul/end_result", bus.result_o, 64'h00000002_0000000E);
      $display("div %-12s restart after annul -> %h (lat %0d)", "annul", bus.result_o, cyc);
      release_op("annul");

      // Reset in the middle of a divide
      drive_op(1'b0, 32'd100, 32'd7);
      repeat (20) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_on/ready", {63'd0, bus.ready_o}, 64'd0);
      chk("rst_on/result", bus.result_o, 64'd0);
      chk("rst_on/stall_eq_start", {63'd0, bus.stallreq_o}, 64'd1);
      bus.start_i = 1'b0;
      #1;
      chk("rst_on/stall_nostart", {63'd0, bus.stallreq_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_div("u55/5", 1'b0, 32'd55, 32'd5, 64'h00000000_0000000B, 33);

      // Reset while a nonzero result is presented
      drive_op(1'b1, 32'hFFFFFF9C, 32'd7);
      wait_ready(1'b1, cyc, sh);
      chk("rst_end/pre_result", bus.result_o, 64'hFFFFFFFE_FFFFFFF2);
      rst = 1'b0;
      #1;
      chk("rst_end/ready", {63'd0, bus.ready_o}, 64'd0);
      chk("rst_end/result", bus.result_o, 64'd0);
      $display("div %-12s reset while ready", "rst_end");
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_div("u100/7b", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
